pc_queue_unit: RTL and testbench

Fetch-stage program-counter queue for the 32-bit PA-RISC pipeline. It holds the front PC (fetch address) and the back PC (next address), implementing PA-RISC's one-instruction branch delay slot. Each cycle it selects the next back PC from the sequential increment or a branch target through a 32-bit 2:1 multiplexer. It also tracks delay-slot state, delay-slot nullification, and a count of executed instructions. The block feeds the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 6 +
 rtl/MUX2x1_32bits.sv | 11 +
 rtl/pc_queue_unit.sv | 48 ++++
 tb/tb_pc_queue_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC width, increment and queue state encoding
package pc_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  typedef enum logic {SEQ = 1'b0, DELAY = 1'b1} state_t;
endpackage

// File: rtl/MUX2x1_32bits.sv
// MUX2x1_32bits: 32-bit 2:1 multiplexer, s selects b
module MUX2x1_32bits
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] a,
  input  logic [PC_W-1:0] b,
  input  logic            s,
  output logic [PC_W-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/pc_queue_unit.sv
// pc_queue_unit: front/back PC queue with one-instruction branch delay slot
module pc_queue_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            le,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            nullify_req,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] npc,
  output logic            in_delay_slot,
  output logic            nullify_out,
  output logic [PC_W-1:0] exec_count,
  output logic            slot_branch_err
);
  state_t state;
  logic sel;
  logic [PC_W-1:0] npc_next;
  // a branch resolved while already in the slot cannot redirect again
  assign sel = branch_taken && state == SEQ;
  assign in_delay_slot = state == DELAY;
  MUX2x1_32bits u_npc_mux (
    .a(npc + PC_INC),
    .b({branch_target[PC_W-1:2], 2'b00}),
    .s(sel),
    .y(npc_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc              <= RESET_PC;
      npc             <= RESET_PC + PC_INC;
      state           <= SEQ;
      nullify_out     <= 1'b0;
      exec_count      <= '0;
      slot_branch_err <= 1'b0;
    end else if (le) begin
      pc              <= npc;
      npc             <= npc_next;
      state           <= sel ? DELAY : SEQ;
      nullify_out     <= nullify_req;
      exec_count      <= exec_count + {{(PC_W-1){1'b0}}, ~nullify_out};
      slot_branch_err <= slot_branch_err | (branch_taken && state == DELAY);
    end
endmodule

// File: tb/tb_pc_queue_unit.sv
// tb_pc_queue_unit: scoreboard bench with behavioural fetch-stream model
module tb_pc_queue_unit;
  logic clk = 0, rst_n = 0, le = 0, branch_taken = 0, nullify_req = 0;
  logic [31:0] branch_target = 0;
  logic [31:0] pc, npc, exec_count;
  logic in_delay_slot, nullify_out, slot_branch_err;
  pc_queue_unit dut (
    .clk(clk), .rst_n(rst_n), .le(le), .branch_taken(branch_taken),
    .branch_target(branch_target), .nullify_req(nullify_req), .pc(pc), .npc(npc),
    .in_delay_slot(in_delay_slot), .nullify_out(nullify_out),
    .exec_count(exec_count), .slot_branch_err(slot_branch_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc, npc, cnt; logic slot, nul, err;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  // model: fetch stream as a pair of addresses plus a pending-slot flag
  logic [31:0] m_pc, m_npc, m_cnt;
  logic m_slot, m_nul, m_err;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".npc"}, npc, e.npc);
    chk({tag, ".exec_count"}, exec_count, e.cnt);
    chk({tag, ".in_delay_slot"}, {31'b0, in_delay_slot}, {31'b0, e.slot});
    chk({tag, ".nullify_out"}, {31'b0, nullify_out}, {31'b0, e.nul});
    chk({tag, ".slot_branch_err"}, {31'b0, slot_branch_err}, {31'b0, e.err});
  endtask
  function automatic exp_t snap();
    return '{pc: m_pc, npc: m_npc, cnt: m_cnt, slot: m_slot, nul: m_nul, err: m_err};
  endfunction
  task automatic model_reset();
    m_pc = 0; m_npc = 4; m_cnt = 0; m_slot = 0; m_nul = 0; m_err = 0;
  endtask
  task automatic cyc(input logic l, input logic bt, input logic [31:0] t, input logic nr);
    @(negedge clk);
    le = l; branch_taken = bt; branch_target = t; nullify_req = nr;
    if (l) begin
      if (!m_nul) m_cnt = m_cnt + 1;
      m_nul = nr;
      m_pc = m_npc;
      if (bt && !m_slot) begin
        m_npc = t & 32'hFFFF_FFFC;
        m_slot = 1;
      end else begin
        m_npc = m_npc + 4;
        if (bt) m_err = 1;
        m_slot = 0;
      end
    end
    q.push_back(snap());
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    le = 0; rst_n = 0;
    model_reset();
    #1 compare("reset", snap());
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("sb", e);
      end
    end
  end
  initial begin
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    settle();
    chk("seq.pc", pc, 32'd12);
    chk("seq.npc", npc, 32'd16);
    chk("seq.cnt", exec_count, 32'd3);
    cyc(1, 1, 32'h0000_0103, 0);
    settle();
    chk("br1.npc", npc, 32'h100);
    chk("br1.slot", {31'b0, in_delay_slot}, 32'd1);
    cyc(1, 0, 0, 0);
    settle();
    chk("br2.pc", pc, 32'h100);
    chk("br2.npc", npc, 32'h104);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h200, i[0]);
    settle();
    chk("stall.pc", pc, 32'h100);
    chk("stall.slot", {31'b0, in_delay_slot}, 32'd0);
    cyc(1, 0, 0, 1);
    settle();
    chk("null.out", {31'b0, nullify_out}, 32'd1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h400, 0);
    cyc(1, 1, 32'h800, 0);
    settle();
    chk("slotbr.npc", npc, 32'h404);
    chk("slotbr.err", {31'b0, slot_branch_err}, 32'd1);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    cyc(1, 0, 0, 0);
    settle();
    chk("wrap.pc", pc, 32'hFFFF_FFFC);
    chk("wrap.npc", npc, 32'h0);
    cyc(1, 1, 32'h40, 0);
    settle();
    #1;
    le = 0; rst_n = 0;
    model_reset();
    #1 compare("async", snap());
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 4) == 0);
    settle();
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
